// File: rtl/multicycle_pkg.sv
// multicycle_pkg: FSM states, opcodes and control encodings shared by multicycle_control.
package multicycle_pkg;
    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
        EXECR, EXECI, ALUWB, BRANCH, JAL, ILLEGAL
    } state_t;

    // Which ALUControl rule applies in the current state.
    typedef enum logic [1:0] {CLS_ADD, CLS_R, CLS_I, CLS_BR} alu_cls_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [9:0] ALU_ADD  = 10'h000;
    localparam logic [9:0] ALU_BEQ  = 10'h008;
    localparam logic [9:0] ALU_BNE  = 10'h009;
    localparam logic [9:0] ALU_BLT  = 10'h00A;
    localparam logic [9:0] ALU_BGE  = 10'h00B;
    localparam logic [9:0] ALU_BLTU = 10'h00C;
    localparam logic [9:0] ALU_BGEU = 10'h00D;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;
    localparam logic [1:0] SRCB_RS2   = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;
    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_READ   = 2'b01;
    localparam logic [1:0] RES_ALURES = 2'b10;
    localparam logic [2:0] IMM_I      = 3'b000;
    localparam logic [2:0] IMM_S      = 3'b001;
    localparam logic [2:0] IMM_B      = 3'b010;
    localparam logic [2:0] IMM_J      = 3'b011;

    function automatic logic [2:0] imm_src(input logic [6:0] op);
        return op == OP_STORE ? IMM_S : op == OP_BRANCH ? IMM_B : op == OP_JAL ? IMM_J : IMM_I;
    endfunction
endpackage

// File: rtl/alu_op_decoder.sv
// alu_op_decoder: maps state class and funct fields to ALUControl plus branch legality.
module alu_op_decoder
    import multicycle_pkg::*;
(
    input  alu_cls_t    cls,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    output logic [9:0]  alu_control,
    output logic        branch_legal
);
    logic [9:0] br_code;

    always_comb begin
        case (funct3)
            3'b000:  br_code = ALU_BEQ;
            3'b001:  br_code = ALU_BNE;
            3'b100:  br_code = ALU_BLT;
            3'b101:  br_code = ALU_BGE;
            3'b110:  br_code = ALU_BLTU;
            3'b111:  br_code = ALU_BGEU;
            default: br_code = ALU_ADD;
        endcase
    end

    assign branch_legal = funct3[2:1] != 2'b01;
    // Only shifts-right carry funct7 meaning in I-type; other immediates leave it zero.
    assign alu_control = cls == CLS_R  ? {funct7, funct3} :
                         cls == CLS_I  ? {funct3 == 3'b101 ? funct7 : 7'd0, funct3} :
                         cls == CLS_BR ? br_code : ALU_ADD;
endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: multicycle RV32I control FSM driving the ALU and unified memory.
// MULTICYCLE_CONTROL_ILLEGAL_TRAP_EN makes ILLEGAL terminal and adds illegal_instr.
module multicycle_control
    import multicycle_pkg::*;
#(
    parameter int unsigned MEM_WAIT_MAX = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr,
    input  logic        Zero,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        MemWrite,
    output logic        AdrSrc,
    output logic        IRWrite,
    output logic        PCWrite,
    output logic        RegWrite,
    output logic [1:0]  ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ResultSrc,
    output logic [2:0]  ImmSrc,
    output logic [9:0]  ALUControl,
    output logic        instr_done,
    output logic        mem_timeout
`ifdef MULTICYCLE_CONTROL_ILLEGAL_TRAP_EN
    ,
    output logic        illegal_instr
`endif
);
    state_t      state, next;
    alu_cls_t    cls;
    logic [6:0]  opcode;
    logic [9:0]  alu_code;
    logic        branch_legal, waiting;
    logic [31:0] wait_cnt;
    logic        unused_bits;

    assign opcode = instr[6:0];
    assign unused_bits = ^{instr[24:15], instr[11:7]};
    assign cls = state == EXECR ? CLS_R : state == EXECI ? CLS_I : state == BRANCH ? CLS_BR : CLS_ADD;
    assign waiting = (state == FETCH || state == MEMREAD || state == MEMWRITE) && !mem_ready;

    alu_op_decoder u_dec (
        .cls          (cls),
        .funct3       (instr[14:12]),
        .funct7       (instr[31:25]),
        .alu_control  (alu_code),
        .branch_legal (branch_legal)
    );

    always_comb begin
        next = FETCH;
        case (state)
            FETCH:    next = mem_ready ? DECODE : FETCH;
            DECODE:   next = opcode == OP_R ? EXECR : opcode == OP_I ? EXECI :
                             (opcode == OP_LOAD || opcode == OP_STORE) ? MEMADR :
                             opcode == OP_BRANCH ? BRANCH : opcode == OP_JAL ? JAL : ILLEGAL;
            MEMADR:   next = opcode == OP_LOAD ? MEMREAD : MEMWRITE;
            MEMREAD:  next = mem_ready ? MEMWB : MEMREAD;
            MEMWRITE: next = mem_ready ? FETCH : MEMWRITE;
            EXECR:    next = ALUWB;
            EXECI:    next = ALUWB;
            JAL:      next = ALUWB;
            BRANCH:   next = branch_legal ? FETCH : ILLEGAL;
`ifdef MULTICYCLE_CONTROL_ILLEGAL_TRAP_EN
            ILLEGAL:  next = ILLEGAL;
`endif
            default:  next = FETCH;
        endcase
    end

    // Reset gates every output so an abandoned instruction cannot write.
    always_comb begin
        mem_req    = 1'b0;
        MemWrite   = 1'b0;
        AdrSrc     = 1'b0;
        IRWrite    = 1'b0;
        PCWrite    = 1'b0;
        RegWrite   = 1'b0;
        instr_done = 1'b0;
        ALUSrcA    = SRCA_PC;
        ALUSrcB    = SRCB_RS2;
        ResultSrc  = RES_ALUOUT;
        if (!reset) begin
            case (state)
                FETCH: begin
                    mem_req   = 1'b1;
                    ALUSrcB   = SRCB_FOUR;
                    ResultSrc = RES_ALURES;
                    IRWrite   = mem_ready;
                    PCWrite   = mem_ready;
                end
                DECODE: begin
                    ALUSrcA = SRCA_OLDPC;
                    ALUSrcB = SRCB_IMM;
                end
                MEMADR: begin
                    ALUSrcA = SRCA_RS1;
                    ALUSrcB = SRCB_IMM;
                end
                MEMREAD: begin
                    mem_req = 1'b1;
                    AdrSrc  = 1'b1;
                end
                MEMWB: begin
                    ResultSrc  = RES_READ;
                    RegWrite   = 1'b1;
                    instr_done = 1'b1;
                end
                MEMWRITE: begin
                    mem_req    = 1'b1;
                    MemWrite   = 1'b1;
                    AdrSrc     = 1'b1;
                    instr_done = mem_ready;
                end
                EXECR: ALUSrcA = SRCA_RS1;
                EXECI: begin
                    ALUSrcA = SRCA_RS1;
                    ALUSrcB = SRCB_IMM;
                end
                ALUWB: begin
                    RegWrite   = 1'b1;
                    instr_done = 1'b1;
                end
                BRANCH: begin
                    ALUSrcA    = SRCA_RS1;
                    PCWrite    = Zero & branch_legal;
                    instr_done = branch_legal;
                end
                JAL: begin
                    ALUSrcA = SRCA_OLDPC;
                    ALUSrcB = SRCB_FOUR;
                    PCWrite = 1'b1;
                end
`ifndef MULTICYCLE_CONTROL_ILLEGAL_TRAP_EN
                ILLEGAL: instr_done = 1'b1;
`endif
                default: ;
            endcase
        end
    end

    assign ALUControl = reset ? ALU_ADD : alu_code;
    assign ImmSrc     = reset ? IMM_I : imm_src(opcode);
`ifdef MULTICYCLE_CONTROL_ILLEGAL_TRAP_EN
    assign illegal_instr = !reset && state == ILLEGAL;
`endif

    // wait_cnt saturates at the limit; a zero limit keeps it at 0 and disables the flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= FETCH;
            wait_cnt    <= '0;
            mem_timeout <= 1'b0;
        end else begin
            state    <= next;
            wait_cnt <= !waiting ? '0 : wait_cnt == MEM_WAIT_MAX ? wait_cnt : wait_cnt + 1'b1;
            if (waiting && MEM_WAIT_MAX != 0 && wait_cnt == MEM_WAIT_MAX)
                mem_timeout <= 1'b1;
        end
    end
endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Control FSM for the multicycle RV32I core; the initiator side of the ALU interface.
- Decodes the instruction register and drives ALUControl and operand selects to the ALU.
- Consumes the ALU Zero (branch-condition) flag.
- Sequences fetch/decode/execute/memory/writeback and handshakes with the unified instruction/data memory.

Parameters:
- MEM_WAIT_MAX, 0: if nonzero, a memory wait longer than this many cycles sets mem_timeout (sticky); 0 disables the check.

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous, active-high reset
- instr  in  32  instruction register contents (opcode [6:0], funct3 [14:12], funct7 [31:25])
- Zero  in  1  ALU branch-condition flag; 1 = branch condition true
- mem_ready  in  1  memory access completes this cycle
- mem_req  out  1  memory access request
- MemWrite  out  1  store strobe, qualified by mem_req
- AdrSrc  out  1  memory address select: 0 = PC, 1 = ALUOut
- IRWrite  out  1  instruction register / OldPC load
- PCWrite  out  1  PC load
- RegWrite  out  1  register file write
- ALUSrcA  out  2  ALU A operand: 00 = PC, 01 = OldPC, 10 = rs1
- ALUSrcB  out  2  ALU B operand: 00 = rs2, 01 = imm, 10 = constant 4
- ResultSrc  out  2  result mux: 00 = ALUOut, 01 = read data, 10 = ALUResult
- ImmSrc  out  3  immediate format: 000 = I, 001 = S, 010 = B, 011 = J
- ALUControl  out  10  ALU operation code
- instr_done  out  1  one-cycle pulse on the last cycle of each instruction
- mem_timeout  out  1  sticky wait-limit flag

Behaviour:
- Clock and reset: one clock `clk`. `reset` is synchronous, active-high.
  - Reset puts the FSM in FETCH and clears mem_timeout.
  - While reset is high: all strobes 0 (mem_req, MemWrite, IRWrite, PCWrite, RegWrite, instr_done); ALUControl = ADD (0); selects = 0.
  - Reset mid-instruction abandons the instruction, with no partial writes afterwards.
- Output style:
  - Moore outputs decoded from state.
  - Exceptions: IRWrite/PCWrite in FETCH = mem_ready; PCWrite in BRANCH = Zero.
  - ImmSrc is combinational from opcode.
- ALUControl encoding:
  - R-type: {funct7, funct3}. ADD = 0, SUB = 0x100, SRA = 0x105.
  - I-ALU: {funct3 == 101 ? funct7 : 0, funct3}.
  - Branch codes: BEQ 0x008, BNE 0x009, BLT 0x00A, BGE 0x00B, BLTU 0x00C, BGEU 0x00D (funct3 000, 001, 100, 101, 110, 111).
  - Address, PC and link arithmetic use ADD.
- States (default next = FETCH):
  - FETCH: mem_req, AdrSrc = 0, A = PC, B = 4, ResultSrc = 10. Holds until mem_ready; then IRWrite = PCWrite = 1 and go to DECODE.
  - DECODE: A = OldPC, B = imm (latches branch target). Next state by opcode:
    - 0110011 → EXECR
    - 0010011 → EXECI
    - 0000011 or 0100011 → MEMADR
    - 1100011 → BRANCH
    - 1101111 → JAL
    - other → ILLEGAL
  - MEMADR: A = rs1, B = imm, ADD. Load goes to MEMREAD, store to MEMWRITE.
  - MEMREAD: mem_req, AdrSrc = 1. Holds until mem_ready, then MEMWB.
  - MEMWB: ResultSrc = 01, RegWrite, instr_done.
  - MEMWRITE: mem_req, MemWrite, AdrSrc = 1. Holds until mem_ready; instr_done in the ready cycle.
  - EXECR: A = rs1, B = rs2, then ALUWB.
  - EXECI: A = rs1, B = imm, then ALUWB.
  - ALUWB: ResultSrc = 00, RegWrite, instr_done.
  - BRANCH: A = rs1, B = rs2, branch code, ResultSrc = 00, PCWrite = Zero, instr_done. funct3 010/011 go to ILLEGAL instead, with no strobes.
  - JAL: A = OldPC, B = 4, ResultSrc = 00 (jump target), PCWrite, then ALUWB (rd = PC + 4).
- Zero is sampled only in the BRANCH cycle and ignored elsewhere.
- mem_ready outside a memory state is ignored.
- Wait counter:
  - Counts consecutive waiting cycles in FETCH/MEMREAD/MEMWRITE; clears on mem_ready or state change.
  - Reaching MEM_WAIT_MAX sets mem_timeout; the FSM keeps waiting.
- Instruction latency:
  - load 5, store 4, R/I 4, branch 3, JAL 4 cycles (each with zero memory wait states).

Optional Feature:
- Macro: MULTICYCLE_CONTROL_ILLEGAL_TRAP_EN.
- Defined: ILLEGAL is terminal.
  - Output illegal_instr = 1 (sticky); all strobes stay 0 until reset.
- Undefined: ILLEGAL behaves as a NOP.
  - One cycle with instr_done = 1, no writes, then FETCH.
  - Port illegal_instr absent.

Decomposition:
- Package multicycle_pkg:
  - state enum
  - opcode constants
  - ALUControl localparams (ADD…BGEU)
  - ALUSrcA/ALUSrcB/ResultSrc/ImmSrc encodings
- Sub-module alu_op_decoder (combinational): {state-class, funct3, funct7} → ALUControl and branch-legal flag.

Test Plan:
- Reset held 2 cycles mid-MEMREAD, then released: state = FETCH; mem_req = 1 on the first post-reset cycle; no RegWrite.
- `add` (0x002081B3), mem_ready = 1: ALUControl = 0x000 in EXECR; RegWrite in cycle 4; instr_done pulses once.
- `sub` (0x402081B3): ALUControl = 0x100. `srai` (0x4020D193): ALUControl = 0x105. `addi` with imm bit30 = 1: ALUControl = 0x000.
- `bne` (funct3 001), Zero = 1: ALUControl = 0x009, PCWrite = 1 in BRANCH. Same with Zero = 0: PCWrite = 0. `bltu`: code 0x00C.
- `lw` with mem_ready low 3 cycles in MEMREAD, MEM_WAIT_MAX = 2: mem_req held 4 cycles; mem_timeout = 1; RegWrite with ResultSrc = 01 in MEMWB.
- Opcode 0x7F, in both macro builds:
  - Trap build: illegal_instr = 1; PCWrite stays 0 for 10 cycles.
  - Non-trap build: instr_done pulse, then mem_req = 1 (next FETCH).
